// File: rtl/cart_mem_arbiter_if.sv
// Memory-side request/acknowledge bus shared by the cartridge arbiter and
// the single-port cart memory controller.
interface cart_mem_arbiter_if #(
  parameter int AW = 20
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_req;
  logic          mem_ack;
  logic [7:0]    mem_dout;

  modport master (
    output mem_addr, mem_din, mem_we, mem_req,
    input  mem_ack, mem_dout
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_req,
    output mem_ack, mem_dout
  );
endinterface

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares one single-port cart memory between the ROM
// download writer, console cartridge reads and the save-RAM port.
// Fixed priority in IDLE: download > CPU > save (> prefetch).
// Optional feature macro: CART_PREFETCH_EN adds a one-entry next-address
// read-ahead for console reads.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; pick the winner, load mem bus, raise req
// BUSY  | access in flight; mem bus held stable until mem_ack
module cart_mem_arbiter #(
  parameter int            AW        = 20,
  parameter logic [AW-1:0] SAVE_BASE = AW'(20'hF8000),
  parameter int            SAVE_AW   = 13
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               ioctl_download_i,
  input  logic               ioctl_wr_i,
  input  logic [AW-1:0]      ioctl_addr_i,
  input  logic [7:0]         ioctl_dout_i,
  output logic               ioctl_wait_o,
  input  logic [AW-1:0]      cart_a_i,
  input  logic               cart_rd_i,
  output logic [7:0]         cart_d_o,
  input  logic [SAVE_AW-1:0] save_a_i,
  input  logic               save_req_i,
  input  logic               save_we_i,
  input  logic [7:0]         save_d_i,
  output logic [7:0]         save_d_o,
  output logic               save_ack_o,
  cart_mem_arbiter_if.master mem
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {SRC_DL, SRC_CPU, SRC_SAVE, SRC_PF} src_t;

  state_t r_state, w_next;
  src_t   r_src, w_src;

  // memory bus registers
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_din;
  logic          r_mem_we;
  logic          r_mem_req;

  // download buffer
  logic          r_dl_pend;
  logic [AW-1:0] r_dl_addr;
  logic [7:0]    r_dl_data;
  logic          r_err;

  // console read tracking
  logic          r_cpu_pend;
  logic [AW-1:0] r_cpu_addr;
  logic          r_last_vld;
  logic [AW-1:0] r_last_addr;
  logic [7:0]    r_cart_d;

  // save port
  logic               r_save_pend;
  logic [SAVE_AW-1:0] r_save_a;
  logic               r_save_we;
  logic [7:0]         r_save_d;
  logic [7:0]         r_save_dout;
  logic               r_save_ack;

  logic          w_issue, w_done, w_cpu_hit;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_din;
  logic          w_we;
  logic          w_cpu_new, w_save_new, w_dl_done;
  logic [AW-1:0] w_save_addr;

  // prefetch hooks; tied off when the feature is not built
  logic          w_pf_hit, w_pf_req;
  logic [AW-1:0] w_pf_addr;
  logic [7:0]    w_pf_data;

  assign w_save_addr = SAVE_BASE + {{(AW-SAVE_AW){1'b0}}, r_save_a};
  assign w_dl_done   = w_done && (r_src == SRC_DL);

  // Same-address reads are served from the held data; a download blanks the CPU.
  assign w_cpu_new  = cart_rd_i && !ioctl_download_i && !r_cpu_pend &&
                      (!r_last_vld || (cart_a_i != r_last_addr));
  // The save requester drops its level while the ack pulse is out, so skip that cycle.
  assign w_save_new = save_req_i && !ioctl_download_i && !r_save_pend && !r_save_ack;

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // FSM next-state, arbitration and bus load values
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_done    = 1'b0;
    w_cpu_hit = 1'b0;
    w_src     = r_src;
    w_addr    = r_mem_addr;
    w_din     = r_mem_din;
    w_we      = r_mem_we;
    case (r_state)
      S_IDLE: begin
        if (r_dl_pend) begin
          w_issue = 1'b1;
          w_src   = SRC_DL;
          w_addr  = r_dl_addr;
          w_din   = r_dl_data;
          w_we    = 1'b1;
        end else if (r_cpu_pend && !ioctl_download_i) begin
          if (w_pf_hit) begin
            w_cpu_hit = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_src   = SRC_CPU;
            w_addr  = r_cpu_addr;
            w_din   = 8'h00;
            w_we    = 1'b0;
          end
        end else if (r_save_pend && !ioctl_download_i) begin
          w_issue = 1'b1;
          w_src   = SRC_SAVE;
          w_addr  = w_save_addr;
          w_din   = r_save_d;
          w_we    = r_save_we;
        end else if (w_pf_req && !ioctl_download_i) begin
          w_issue = 1'b1;
          w_src   = SRC_PF;
          w_addr  = w_pf_addr;
          w_din   = 8'h00;
          w_we    = 1'b0;
        end
        if (w_issue) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (mem.mem_ack) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory bus: loaded on issue, held through BUSY, req dropped on ack
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mem_addr <= '0;
      r_mem_din  <= 8'h00;
      r_mem_we   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_src      <= SRC_DL;
    end else if (w_issue) begin
      r_mem_addr <= w_addr;
      r_mem_din  <= w_din;
      r_mem_we   <= w_we;
      r_mem_req  <= 1'b1;
      r_src      <= w_src;
    end else if (w_done) begin
      r_mem_req  <= 1'b0;
    end
  end

  // Download buffer; an ack retiring the old entry frees the slot in the same cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dl_pend <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      if (w_dl_done) r_dl_pend <= 1'b0;
      if (ioctl_wr_i) begin
        if (!r_dl_pend || w_dl_done) begin
          r_dl_pend <= 1'b1;
          r_dl_addr <= ioctl_addr_i;
          r_dl_data <= ioctl_dout_i;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Console read capture and completion (from memory or the prefetch register)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cpu_pend  <= 1'b0;
      r_cpu_addr  <= '0;
      r_last_vld  <= 1'b0;
      r_last_addr <= '0;
      r_cart_d    <= 8'hFF;
    end else begin
      if (w_cpu_new) begin
        r_cpu_pend <= 1'b1;
        r_cpu_addr <= cart_a_i;
      end
      if (w_done && (r_src == SRC_CPU)) begin
        r_cpu_pend  <= 1'b0;
        r_cart_d    <= mem.mem_dout;
        r_last_vld  <= 1'b1;
        r_last_addr <= r_cpu_addr;
      end
      if (w_cpu_hit) begin
        r_cpu_pend  <= 1'b0;
        r_cart_d    <= w_pf_data;
        r_last_vld  <= 1'b1;
        r_last_addr <= r_cpu_addr;
      end
    end
  end

  // Save port capture, read data and one-cycle done pulse
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_save_pend <= 1'b0;
      r_save_a    <= '0;
      r_save_we   <= 1'b0;
      r_save_d    <= 8'h00;
      r_save_dout <= 8'h00;
      r_save_ack  <= 1'b0;
    end else begin
      r_save_ack <= 1'b0;
      if (w_save_new) begin
        r_save_pend <= 1'b1;
        r_save_a    <= save_a_i;
        r_save_we   <= save_we_i;
        r_save_d    <= save_d_i;
      end
      if (w_done && (r_src == SRC_SAVE)) begin
        r_save_pend <= 1'b0;
        r_save_ack  <= 1'b1;
        if (!r_mem_we) r_save_dout <= mem.mem_dout;
      end
    end
  end

`ifdef CART_PREFETCH_EN
  logic          r_pf_vld;
  logic          r_pf_pend;
  logic [AW-1:0] r_pf_addr;
  logic [7:0]    r_pf_data;
  logic          w_wr_issue;

  // Any write reaching memory may alias the prefetched byte, so drop it.
  assign w_wr_issue = w_issue && w_we;

  // Prefetch register: armed by each completed CPU read, filled at lowest priority
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pf_vld  <= 1'b0;
      r_pf_pend <= 1'b0;
      r_pf_addr <= '0;
      r_pf_data <= 8'h00;
    end else if (w_wr_issue) begin
      r_pf_vld  <= 1'b0;
      r_pf_pend <= 1'b0;
    end else if ((w_done && (r_src == SRC_CPU)) || w_cpu_hit) begin
      r_pf_vld  <= 1'b0;
      r_pf_pend <= 1'b1;
      r_pf_addr <= r_cpu_addr + 1'b1;
    end else if (w_done && (r_src == SRC_PF)) begin
      r_pf_vld  <= 1'b1;
      r_pf_pend <= 1'b0;
      r_pf_data <= mem.mem_dout;
    end
  end

  assign w_pf_hit  = r_pf_vld && (r_cpu_addr == r_pf_addr);
  assign w_pf_req  = r_pf_pend;
  assign w_pf_addr = r_pf_addr;
  assign w_pf_data = r_pf_data;
`else
  assign w_pf_hit  = 1'b0;
  assign w_pf_req  = 1'b0;
  assign w_pf_addr = '0;
  assign w_pf_data = 8'h00;
`endif

  assign ioctl_wait_o = r_dl_pend;
  assign cart_d_o     = r_cart_d;
  assign save_d_o     = r_save_dout;
  assign save_ack_o   = r_save_ack;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_din  = r_mem_din;
  assign mem.mem_we   = r_mem_we;
  assign mem.mem_req  = r_mem_req;

endmodule
